// File: rtl/intc_pkg.sv
// intc_pkg: register map, controller states and reset constants for the interrupt controller
package intc_pkg;
  localparam logic [3:0] ADDR_PEND    = 4'd0;
  localparam logic [3:0] ADDR_MASK    = 4'd1;
  localparam logic [3:0] ADDR_EDGE    = 4'd2;
  localparam logic [3:0] ADDR_VBASE   = 4'd3;
  localparam logic [3:0] ADDR_RETADDR = 4'd4;
  localparam logic [3:0] ADDR_STATUS  = 4'd5;
  localparam logic [15:0] VBASE_RST   = 16'h0010;
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, SERVICE = 2'd2} state_t;
endpackage

// File: rtl/intc_sync_edge.sv
// intc_sync_edge: two-flop synchronizer with rising-edge detect for one interrupt line
module intc_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic irq,
  output logic level,
  output logic rise
);
  logic meta, sync_q, sync_qq;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) {meta, sync_q, sync_qq} <= '0;
    else {meta, sync_q, sync_qq} <= {irq, meta, sync_q};
  end
  assign level = sync_q;
  assign rise  = sync_q & ~sync_qq;
endmodule

// File: rtl/interrupt_controller.sv
// interrupt_controller: prioritised NUM_CH-channel interrupt controller; define INTC_NEST_EN for nested service with a NEST_DEPTH return stack
module interrupt_controller
  import intc_pkg::*;
#(
  parameter int NUM_CH     = 8,
  parameter int DATA_W     = 16,
  parameter int VEC_STRIDE = 2,
  parameter int NEST_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] irq_in,
  input  logic [3:0]        io_addr,
  input  logic              io_write,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  input  logic              int_en,
  input  logic              int_dis,
  output logic              int_req,
  input  logic              int_ack,
  output logic [DATA_W-1:0] int_vector,
  input  logic [DATA_W-1:0] pc_in,
  input  logic              iret,
  output logic [DATA_W-1:0] ret_addr
);
  logic [NUM_CH-1:0] rise, lvl, pend, mask, edge_sel, in_svc, elig, cand, w1c, ack_clr, onehot;
  logic [DATA_W-1:0] vbase, vec;
  logic [3:0] act_ch, win;
  logic gie, err, any, hold, ack_ok, iret_ok, err_set, err_clr;
  state_t state, state_nx, ret_state, iret_state;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_sync
    intc_sync_edge u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .irq   (irq_in[i]),
      .level (lvl[i]),
      .rise  (rise[i])
    );
  end
  assign elig    = pend & mask & {NUM_CH{gie}};
  assign onehot  = NUM_CH'(1) << act_ch;
  assign hold    = |(elig & onehot);
  assign ack_ok  = int_ack && state == REQ;
  assign iret_ok = iret && state == SERVICE && |in_svc;
  assign err_set = (int_ack && state != REQ) || (iret && !iret_ok);
  assign err_clr = io_write && io_addr == ADDR_STATUS && wr_data[6];
  assign w1c     = io_write && io_addr == ADDR_PEND ? wr_data[NUM_CH-1:0] : '0;
  assign ack_clr = ack_ok ? onehot & edge_sel : '0;
`ifdef INTC_NEST_EN
  localparam int SPW = $clog2(NEST_DEPTH + 1);
  logic [DATA_W-1:0] stack [NEST_DEPTH];
  logic [SPW-1:0] sp;
  logic [NUM_CH-1:0] lowest;
  assign lowest     = in_svc & (~in_svc + NUM_CH'(1));
  assign cand       = sp == SPW'(NEST_DEPTH) || state == REQ ? '0 : elig & (lowest - NUM_CH'(1));
  assign ret_state  = |in_svc ? SERVICE : IDLE;
  assign iret_state = |(in_svc & (in_svc - NUM_CH'(1))) ? SERVICE : IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp <= '0;
      for (int i = 0; i < NEST_DEPTH; i++) stack[i] <= '0;
    end else if (ack_ok) begin
      for (int i = 0; i < NEST_DEPTH; i++) if (sp == SPW'(i)) stack[i] <= pc_in;
      sp <= sp + 1'b1;
    end else if (iret_ok) begin
      sp <= sp - 1'b1;
    end
  end
  always_comb begin
    ret_addr = '0;
    for (int i = 0; i < NEST_DEPTH; i++) ret_addr = sp == SPW'(i + 1) ? stack[i] : ret_addr;
  end
`else
  assign cand       = state == IDLE ? elig : '0;
  assign ret_state  = IDLE;
  assign iret_state = IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ret_addr <= '0;
    else if (ack_ok) ret_addr <= pc_in;
  end
`endif
  assign any = |cand;
  always_comb begin
    win = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) win = cand[i] ? 4'(i) : win;
  end
  always_comb begin
    state_nx = state == IDLE ? (any ? REQ : IDLE)
             : state == REQ  ? (int_ack ? SERVICE : hold ? REQ : ret_state)
             : any ? REQ : iret_ok ? iret_state : SERVICE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend     <= '0;
      mask     <= '0;
      edge_sel <= '1;
      vbase    <= DATA_W'(VBASE_RST);
      gie      <= 1'b0;
      err      <= 1'b0;
      state    <= IDLE;
      act_ch   <= '0;
      vec      <= '0;
      in_svc   <= '0;
    end else begin
      pend   <= (edge_sel & ((pend & ~w1c & ~ack_clr) | rise)) | (~edge_sel & lvl);
      gie    <= int_dis ? 1'b0 : int_en ? 1'b1 : gie;
      err    <= (err & ~err_clr) | err_set;
      state  <= state_nx;
      in_svc <= (iret_ok ? in_svc & (in_svc - NUM_CH'(1)) : in_svc) | (ack_ok ? onehot : '0);
      if (io_write && io_addr == ADDR_MASK) mask <= wr_data[NUM_CH-1:0];
      if (io_write && io_addr == ADDR_EDGE) edge_sel <= wr_data[NUM_CH-1:0];
      if (io_write && io_addr == ADDR_VBASE) vbase <= wr_data;
      if (state_nx == REQ && state != REQ) begin
        act_ch <= win;
        vec    <= vbase + DATA_W'(win) * DATA_W'(VEC_STRIDE);
      end
    end
  end
  assign int_req    = state == REQ;
  assign int_vector = vec;
  assign rd_data = io_addr == ADDR_PEND    ? DATA_W'(pend)
                 : io_addr == ADDR_MASK    ? DATA_W'(mask)
                 : io_addr == ADDR_EDGE    ? DATA_W'(edge_sel)
                 : io_addr == ADDR_VBASE   ? vbase
                 : io_addr == ADDR_RETADDR ? ret_addr
                 : io_addr == ADDR_STATUS  ? DATA_W'({gie, err, state, act_ch})
                 : '0;
endmodule

// File: tb/tb_interrupt_controller.sv
// tb_interrupt_controller: directed and randomized checks of interrupt_controller against a transaction-level model
module tb_interrupt_controller;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  irq_in = '0;
  logic [3:0]  io_addr = '0;
  logic        io_write = 1'b0;
  logic [15:0] wr_data = '0;
  logic [15:0] rd_data;
  logic        int_en = 1'b0;
  logic        int_dis = 1'b0;
  logic        int_req;
  logic        int_ack = 1'b0;
  logic [15:0] int_vector;
  logic [15:0] pc_in = '0;
  logic        iret = 1'b0;
  logic [15:0] ret_addr;
  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;
  interrupt_controller dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .irq_in     (irq_in),
    .io_addr    (io_addr),
    .io_write   (io_write),
    .wr_data    (wr_data),
    .rd_data    (rd_data),
    .int_en     (int_en),
    .int_dis    (int_dis),
    .int_req    (int_req),
    .int_ack    (int_ack),
    .int_vector (int_vector),
    .pc_in      (pc_in),
    .iret       (iret),
    .ret_addr   (ret_addr)
  );
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    io_addr = a;
    wr_data = d;
    io_write = 1'b1;
    tick();
    io_write = 1'b0;
  endtask
  task automatic rd(input logic [3:0] a, output logic [15:0] d);
    io_addr = a;
    #1;
    d = rd_data;
  endtask
  task automatic wait_req(input string tag);
    for (int i = 0; i < 20 && !int_req; i++) tick();
    chk(tag, int_req, 1);
  endtask
  task automatic ack(input logic [15:0] pc);
    pc_in = pc;
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
  endtask
  task automatic do_iret();
    iret = 1'b1;
    tick();
    iret = 1'b0;
  endtask
  task automatic pulse(input logic [7:0] lines);
    irq_in = lines;
    tick(3);
    irq_in = '0;
  endtask
  initial begin
    logic [15:0] d, vb, pc;
    logic [7:0] msk, fired;
    int q[$];
    tick(3);
    rst_n = 1'b1;
    tick();
    chk("rst_int_req", int_req, 0);
    chk("rst_int_vector", int_vector, 0);
    chk("rst_ret_addr", ret_addr, 0);
    rd(0, d); chk("rst_pend", d, 0);
    rd(1, d); chk("rst_mask", d, 0);
    rd(2, d); chk("rst_edge", d, 16'h00FF);
    tick();
    rd(3, d); chk("rst_vbase", d, 16'h0010);
    rd(5, d); chk("rst_status", d, 0);
    rd(9, d); chk("unused_addr", d, 0);
    // request latency from a single edge
    wr(1, 16'h0001);
    int_en = 1'b1; tick(); int_en = 1'b0;
    irq_in = 8'h01;
    tick(2);
    rd(0, d); chk("t1_pend_k2", d, 0);
    tick();
    rd(0, d); chk("t1_pend_k3", d, 16'h0001);
    chk("t1_req_k3", int_req, 0);
    tick();
    chk("t1_req_k4", int_req, 1);
    chk("t1_vector", int_vector, 16'h0010);
    irq_in = '0;
    ack(16'h1234);
    chk("t2_req_after_ack", int_req, 0);
    rd(0, d); chk("t2_pend", d, 0);
    rd(4, d); chk("t2_retaddr", d, 16'h1234);
    rd(5, d); chk("t2_state_service", d[5:4], 2);
    chk("t2_active_ch", d[3:0], 0);
    do_iret();
    rd(5, d); chk("t2_state_idle", d[5:4], 0);
    tick(6);
    chk("t2_no_second_req", int_req, 0);
    // simultaneous requests resolve by priority
    wr(1, 16'h00FF);
    pulse(8'h28);
    wait_req("t3_req_a");
    chk("t3_vector_ch3", int_vector, 16'h0016);
    ack(16'h0300);
    do_iret();
    wait_req("t3_req_b");
    chk("t3_vector_ch5", int_vector, 16'h001A);
    ack(16'h0500);
    do_iret();
    tick(6);
    chk("t3_idle", int_req, 0);
    // losing eligibility withdraws the request
    pulse(8'h04);
    wait_req("t4_req");
    chk("t4_vector_ch2", int_vector, 16'h0014);
    wr(1, 16'h0000);
    tick();
    chk("t4_req_dropped", int_req, 0);
    rd(5, d); chk("t4_state_idle", d[5:4], 0);
    rd(0, d); chk("t4_pend_kept", d, 16'h0004);
    wr(0, 16'h0004);
    rd(0, d); chk("t4_w1c", d, 0);
    // level-sensitive channel re-requests while held
    wr(2, 16'h00FD);
    wr(1, 16'h0002);
    irq_in = 8'h02;
    wait_req("t5_req_a");
    chk("t5_vector_ch1", int_vector, 16'h0012);
    wr(0, 16'h0002);
    rd(0, d); chk("t5_w1c_ignored", d, 16'h0002);
    ack(16'h0111);
    rd(0, d); chk("t5_pend_after_ack", d, 16'h0002);
    do_iret();
    wait_req("t5_req_b");
    irq_in = '0;
    ack(16'h0222);
    tick(4);
    do_iret();
    tick(6);
    chk("t5_released", int_req, 0);
    rd(0, d); chk("t5_pend_clear", d, 0);
    wr(2, 16'h00FF);
    // protocol errors and global enable
    do_iret();
    rd(5, d); chk("err_iret_idle", d[6], 1);
    wr(5, 16'h0040);
    rd(5, d); chk("err_cleared", d[6], 0);
    ack(16'h0000);
    rd(5, d); chk("err_ack_idle", d[6], 1);
    wr(5, 16'h0040);
    int_en = 1'b1; int_dis = 1'b1; tick(); int_en = 1'b0; int_dis = 1'b0;
    rd(5, d); chk("gie_dis_wins", d[7], 0);
    wr(1, 16'h00FF);
    pulse(8'h10);
    tick(6);
    chk("gie_off_no_req", int_req, 0);
    int_en = 1'b1; tick(); int_en = 1'b0;
    wait_req("gie_on_req");
    chk("gie_on_vector", int_vector, 16'h0018);
    ack(16'h0400);
    do_iret();
    tick(4);
`ifdef INTC_NEST_EN
    pulse(8'h10);
    wait_req("n_req_ch4");
    ack(16'h0100);
    pulse(8'h02);
    wait_req("n_req_ch1");
    chk("n_vector_ch1", int_vector, 16'h0012);
    ack(16'h0200);
    rd(4, d); chk("n_retaddr_nested", d, 16'h0200);
    do_iret();
    rd(4, d); chk("n_retaddr_first", d, 16'h0100);
    rd(5, d); chk("n_state_service", d[5:4], 2);
    do_iret();
    rd(5, d); chk("n_state_idle", d[5:4], 0);
    for (int c = 7; c >= 4; c--) begin
      pulse(8'(1 << c));
      wait_req("n_fill_req");
      ack(16'(16'h0700 + c));
    end
    pulse(8'h01);
    tick(6);
    chk("n_full_blocked", int_req, 0);
    do_iret();
    wait_req("n_unblocked");
    chk("n_vector_ch0", int_vector, 16'h0010);
    ack(16'h0800);
    repeat (4) do_iret();
    rd(5, d); chk("n_drained", d[5:4], 0);
    tick(4);
`endif
    // randomized bursts: each burst is served in ascending channel order
    for (int it = 0; it < 16; it++) begin
      vb = 16'($urandom) & 16'hFFF0;
      msk = 8'($urandom);
      fired = 8'($urandom_range(1, 255));
      wr(3, vb);
      wr(1, {8'h00, msk});
      q.delete();
      for (int c = 0; c < 8; c++) if (fired[c] && msk[c]) q.push_back(c);
      pulse(fired);
      tick(3);
      while (q.size() > 0) begin
        int c;
        c = q.pop_front();
        wait_req("rnd_req");
        chk("rnd_vector", int_vector, 32'(vb + 16'(c * 2)));
        rd(5, d); chk("rnd_active_ch", d[3:0], 32'(c));
        pc = 16'($urandom);
        ack(pc);
        rd(4, d); chk("rnd_retaddr", d, pc);
        do_iret();
      end
      tick(4);
      chk("rnd_idle", int_req, 0);
      rd(0, d); chk("rnd_pend_left", d, {8'h00, fired & ~msk});
      wr(0, 16'h00FF);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
